// File: rtl/memory_block_wrapper.sv
// SPI-slave front end for a single-port RAM: 2-bit command + 8-bit payload frames
// set the write/read address, write a word, or shift a word out on MISO.
module memory_block_wrapper #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO
);
  localparam int CNT_W = $clog2(DATA_SIZE);

  typedef enum logic [2:0] {IDLE, CMD, PAYLOAD, READ_OUT, WAIT_END} state_t;

  state_t                 state, state_nxt;
  logic                   cmd_hi, cmd_lo;
  logic [CNT_W-1:0]       cnt;
  logic [DATA_SIZE-1:0]   shreg;
  logic [DATA_SIZE-1:0]   payload_word;
  logic [ADDR_SIZE-1:0]   wr_addr, rd_addr;
  logic [DATA_SIZE-1:0]   mem [MEM_DEPTH];
  logic [DATA_SIZE-1:0]   rd_word;
  logic                   last_bit, frame_done, rd_load, mem_we;

  assign last_bit     = (cnt == CNT_W'(DATA_SIZE-1));
  assign payload_word = {shreg[DATA_SIZE-2:0], MOSI};
  assign rd_word      = mem[rd_addr];

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    rd_load    = 1'b0;
    mem_we     = 1'b0;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = CMD;
        CMD: begin
          if (cmd_hi && MOSI) begin
            state_nxt = READ_OUT;
            rd_load   = 1'b1;
          end else begin
            state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (last_bit) begin
            state_nxt  = WAIT_END;
            frame_done = 1'b1;
            mem_we     = ({cmd_hi, cmd_lo} == 2'b01);
          end
        end
        READ_OUT: if (last_bit) state_nxt = WAIT_END;
        WAIT_END: state_nxt = WAIT_END;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      cmd_hi  <= 1'b0;
      cmd_lo  <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      MISO    <= 1'b0;
    end else begin
      state <= state_nxt;
      // MISO idles low unless a read frame is actively shifting
      MISO  <= 1'b0;
      if (SS_n) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            cmd_hi <= MOSI;
            cnt    <= '0;
          end
          CMD: begin
            cmd_lo <= MOSI;
            cnt    <= '0;
            if (rd_load) begin
              MISO  <= rd_word[DATA_SIZE-1];
              shreg <= {rd_word[DATA_SIZE-2:0], 1'b0};
            end
          end
          PAYLOAD: begin
            shreg <= payload_word;
            cnt   <= cnt + 1'b1;
            if (frame_done) begin
              if ({cmd_hi, cmd_lo} == 2'b00) wr_addr <= payload_word[ADDR_SIZE-1:0];
              if ({cmd_hi, cmd_lo} == 2'b10) rd_addr <= payload_word[ADDR_SIZE-1:0];
            end
          end
          READ_OUT: begin
            if (!last_bit) begin
              MISO  <= shreg[DATA_SIZE-1];
              shreg <= {shreg[DATA_SIZE-2:0], 1'b0};
              cnt   <= cnt + 1'b1;
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= payload_word;
  end

endmodule

// File: tb/tb_memory_block_wrapper.sv
// Directed bench for memory_block_wrapper: drives SPI frames on falling edges and
// samples MISO on falling edges, as a master would.
module tb_memory_block_wrapper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic MOSI = 1'b0;
  logic SS_n = 1'b1;
  logic MISO;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] rd;
  logic       tail;

  memory_block_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One frame of {cmd, data} plus optional trailing junk bits; returns the
  // byte seen on MISO after the command and the MISO level after the frame.
  task automatic xfer(input logic [1:0] cmd, input logic [7:0] data, input int extra,
                      output logic [7:0] rdv, output logic tl);
    logic [9:0] bits;
    bits = {cmd, data};
    rdv  = 8'h00;
    for (int i = 0; i < 10 + extra; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 10) rdv[9-i] = MISO;
      SS_n = 1'b0;
      MOSI = (i < 10) ? bits[9-i] : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    tl   = MISO;
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    logic t;
    xfer(2'b00, a, 0, r, t);
    xfer(2'b01, d, 0, r, t);
  endtask

  task automatic rd_at(input logic [7:0] a, output logic [7:0] r, output logic t);
    logic [7:0] r0;
    logic t0;
    xfer(2'b10, a, 0, r0, t0);
    xfer(2'b11, 8'h00, 0, r, t);
  endtask

  initial begin
    // 1: reset with SS_n high, then MOSI activity while deselected
    repeat (5) @(negedge clk);
    check("reset_miso", {7'b0, MISO}, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      MOSI = i[0];
    end
    @(negedge clk);
    check("deselected_miso", {7'b0, MISO}, 8'h00);

    // 2: basic write/read of 0x0B at 0x64
    xfer(2'b00, 8'h64, 0, rd, tail);
    xfer(2'b01, 8'h0B, 0, rd, tail);
    xfer(2'b10, 8'h64, 0, rd, tail);
    xfer(2'b11, 8'hA7, 0, rd, tail);
    check("basic_read", rd, 8'h0B);
    check("basic_tail", {7'b0, tail}, 8'h00);

    // 3: fill 100..199 with 11*k (wrapping after 253), read all back
    for (int i = 0; i < 100; i++) wr(8'(100 + i), 8'(11 * ((i % 23) + 1)));
    for (int i = 0; i < 100; i++) begin
      rd_at(8'(100 + i), rd, tail);
      check($sformatf("sweep_%0d", 100 + i), rd, 8'(11 * ((i % 23) + 1)));
    end

    // 4: aborted write frame must not touch memory
    wr(8'h05, 8'h5A);
    xfer(2'b00, 8'h05, 0, rd, tail);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = (i == 1) ? 1'b1 : 1'b1 ^ (i == 0);
    end
    @(negedge clk);
    check("abort_miso", {7'b0, MISO}, 8'h00);
    SS_n = 1'b1;
    @(negedge clk);
    rd_at(8'h05, rd, tail);
    check("abort_no_write", rd, 8'h5A);
    xfer(2'b01, 8'hA5, 0, rd, tail);
    xfer(2'b11, 8'h00, 0, rd, tail);
    check("after_abort_write", rd, 8'hA5);

    // 5: reset mid-frame clears address latches, keeps memory
    wr(8'h00, 8'h3C);
    xfer(2'b10, 8'h64, 0, rd, tail);
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b1;
    @(negedge clk); MOSI = 1'b1;
    @(negedge clk); MOSI = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_miso", {7'b0, MISO}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    SS_n  = 1'b1;
    @(negedge clk);
    xfer(2'b11, 8'h00, 0, rd, tail);
    check("rd_addr_reset", rd, 8'h3C);
    xfer(2'b01, 8'h77, 0, rd, tail);
    xfer(2'b11, 8'h00, 0, rd, tail);
    check("wr_addr_reset", rd, 8'h77);

    // 6: extreme addresses/data with trailing junk bits
    xfer(2'b00, 8'hFF, 12, rd, tail);
    check("junk_tail_a", {7'b0, tail}, 8'h00);
    xfer(2'b01, 8'hFF, 12, rd, tail);
    xfer(2'b00, 8'h00, 12, rd, tail);
    xfer(2'b01, 8'h00, 12, rd, tail);
    check("junk_tail_b", {7'b0, tail}, 8'h00);
    rd_at(8'hFF, rd, tail);
    check("read_ff", rd, 8'hFF);
    check("read_ff_tail", {7'b0, tail}, 8'h00);
    rd_at(8'h00, rd, tail);
    check("read_00", rd, 8'h00);
    xfer(2'b10, 8'hFF, 0, rd, tail);
    xfer(2'b11, 8'h00, 12, rd, tail);
    check("read_ff_junk", rd, 8'hFF);
    check("read_ff_junk_tail", {7'b0, tail}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
